// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: state encoding, ACK timeout,
// status-counter width and the reload value of the shared down-counter.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAck,
    StShift,
    StGap,
    StFlush
  } state_e;

  localparam int unsigned AckTimeout     = 4;
  localparam int unsigned SentCountWidth = 16;
  localparam int unsigned CntWidth       = 8;

  // A gap of 0 never enters the gap state, so its reload value is irrelevant.
  function automatic logic [CntWidth-1:0] gap_load(input int unsigned gap);
    return (gap > 0) ? CntWidth'(gap - 1) : '0;
  endfunction

endpackage

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops one character from a show-ahead FIFO, launches the
// transmitter, waits for it to finish, then inserts an optional idle gap.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Gap   = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      cts_i,
  input  logic                      flush_i,
  input  logic                      fifo_empty_i,
  input  logic [Width-1:0]          fifo_odata_i,
  output logic                      fifo_rd_en_o,
  output logic [Width-1:0]          tx_data_o,
  output logic                      tx_start_o,
  input  logic                      tx_busy_i,
  output logic                      active_o,
  output logic [SentCountWidth-1:0] sent_count_o
);

  localparam logic [CntWidth-1:0] GapLoad = gap_load(Gap);
  localparam logic [CntWidth-1:0] AckLoad = CntWidth'(AckTimeout - 1);

  state_e                    state_q;
  logic [CntWidth-1:0]       cnt_q;
  logic [Width-1:0]          tx_data_q;
  logic [SentCountWidth-1:0] sent_count_q;
  logic                      launch;

  always_comb begin
    launch = (state_q == StIdle) && !flush_i && enable_i && cts_i && !fifo_empty_i;
    // Gated by reset so the strobe is quiet while the block is held in reset.
    fifo_rd_en_o = rst_ni && (launch || ((state_q == StFlush) && !fifo_empty_i));
    tx_start_o   = (state_q == StStart);
    active_o     = (state_q != StIdle);
    tx_data_o    = tx_data_q;
    sent_count_o = sent_count_q;
  end

  // cnt_q serves as the ACK timeout in StAck and the idle-gap timer in StGap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      sent_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (flush_i) begin
            state_q <= StFlush;
          end else if (launch) begin
            tx_data_q <= fifo_odata_i;
            state_q   <= StStart;
          end
        end
        StStart: begin
          sent_count_q <= sent_count_q + SentCountWidth'(1);
          cnt_q        <= AckLoad;
          state_q      <= StAck;
        end
        StAck: begin
          if (tx_busy_i || (cnt_q == '0)) begin
            state_q <= StShift;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end
        StShift: begin
          if (!tx_busy_i) begin
            if (Gap > 0) begin
              cnt_q   <= GapLoad;
              state_q <= StGap;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StGap: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end
        StFlush: begin
          if (fifo_empty_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
